ps2_scan_rx: RTL and testbench

//  PS/2 keyboard front end. Deserialises 11-bit device-to-host frames into scan codes and strips

---
 rtl/ps2_scan_rx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// ps2_scan_rx
// PS/2 keyboard receive front end. Synchronises and de-glitches the keyboard
// clock, deserialises 11-bit device-to-host frames, checks odd parity and the
// stop bit, strips E0 (extended) and F0 xx (break) sequences, and presents each
// make code once to the downstream command decoder.
//
// Ports
//   CLK       in   1  system clock, all logic on posedge
//   RESET     in   1  synchronous active-high reset
//   ps2_clk   in   1  raw keyboard clock pin (asynchronous)
//   ps2_data  in   1  raw keyboard data pin (asynchronous)
//   Dato      out  8  last accepted make code, held until the next one
//   flag      out  1  one-cycle pulse, new make code on Dato (Dato settled a cycle earlier)
//   rx_err    out  1  one-cycle pulse on parity, stop-bit or timeout error
// ----------------------------------------------------------------------------
module ps2_scan_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] Dato,
  output logic       flag,
  output logic       rx_err
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Input synchronisers and filter state
  logic              r_clk_s1;
  logic              r_clk_s2;
  logic              r_dat_s1;
  logic              r_dat_s2;
  logic              r_filt;
  logic [FCNT_W-1:0] r_fcnt;

  // Frame FSM and datapath
  state_t            r_state;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic              r_par;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_break;

  // Output registers
  logic [7:0]        r_dato;
  logic              r_flag_pend;
  logic              r_flag;
  logic              r_err;

  logic              w_filt_flip;
  logic              w_fall;
  logic              w_timeout;
  logic              w_frame_ok;

  // Filtered clock flips once the synced pin has disagreed for FILTER_LEN samples in a row
  assign w_filt_flip = (r_clk_s2 != r_filt) && (r_fcnt == FCNT_W'(FILTER_LEN - 1));
  assign w_fall      = w_filt_flip && r_filt;

  // Watchdog expires only on a cycle that is not itself a falling edge
  assign w_timeout   = (r_state != ST_IDLE) && !w_fall &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));

  // Odd parity over data+parity, and a high stop bit (sampled this cycle)
  assign w_frame_ok  = (^{r_shift, r_par}) && r_dat_s2;

  // Two-flop synchronisers; idle line is high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock de-glitch filter: any agreeing sample restarts the run count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (w_filt_flip) begin
      r_filt <= r_clk_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  // Mid-frame watchdog, reloaded on every falling edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wdog <= '0;
    end else if (w_fall || (r_state == ST_IDLE) || w_timeout) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  // Frame FSM, prefix stripping and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_break     <= 1'b0;
      r_dato      <= 8'h00;
      r_flag_pend <= 1'b0;
      r_flag      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // flag trails the Dato update by one cycle
      r_flag      <= r_flag_pend;
      r_flag_pend <= 1'b0;
      r_err       <= 1'b0;

      if (w_timeout) begin
        r_state <= ST_IDLE;
        r_err   <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            // A high start bit is treated as noise, not an error
            if (!r_dat_s2) begin
              r_state  <= ST_DATA;
              r_bitcnt <= 3'd0;
            end
          end
          ST_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_frame_ok) begin
              r_err <= 1'b1;
            end else if (r_shift == 8'hE0) begin
              r_break <= r_break;
            end else if (r_shift == 8'hF0) begin
              r_break <= 1'b1;
            end else if (r_break) begin
              // release code of a broken key
              r_break <= 1'b0;
            end else begin
              r_dato      <= r_shift;
              r_flag_pend <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign Dato   = r_dato;
  assign flag   = r_flag;
  assign rx_err = r_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scan_rx
// Directed bench for ps2_scan_rx: drives PS/2 frames on the pins, tracks flag,
// rx_err and Dato stability from a negedge monitor, and checks each step
// against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_ps2_scan_rx;

  localparam int unsigned TIMEOUT = 500;
  localparam int unsigned HALF    = 40;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] Dato;
  logic       flag;
  logic       rx_err;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state
  int         n_flag = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         n_unstable = 0;
  int         n_wide = 0;
  logic [7:0] flag_dato = 8'h00;
  logic [7:0] dato_prev = 8'h00;
  logic       flag_prev = 1'b0;

  int f0;
  int e0;

  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .Dato     (Dato),
    .flag     (flag),
    .rx_err   (rx_err)
  );

  always #5 CLK = ~CLK;

  // Pulse bookkeeping, sampled away from the active edge
  always @(negedge CLK) begin
    if (flag) begin
      n_flag    = n_flag + 1;
      flag_dato = Dato;
      if (Dato !== dato_prev) n_unstable = n_unstable + 1;
      if (flag_prev) n_wide = n_wide + 1;
    end
    if (rx_err) n_err = n_err + 1;
    if (flag && rx_err) n_both = n_both + 1;
    dato_prev = Dato;
    flag_prev = flag;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send the first n bits of a frame; the keyboard changes data while its clock is high
  task automatic send_bits(input logic [7:0] b, input bit flip_par, input int n);
    logic [10:0] fr;
    logic        par;
    par = ~(^b) ^ flip_par;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  initial begin
    // Reset state
    cyc(5);
    @(negedge CLK);
    chk("reset_dato", 32'(Dato), 32'h00);
    chk("reset_flag", 32'(flag), 32'h0);
    chk("reset_err", 32'(rx_err), 32'h0);
    cyc(1);
    RESET = 1'b0;
    cyc(20);

    // Single make code 0x43
    f0 = n_flag; e0 = n_err;
    send_frame(8'h43);
    chk("m43_flags", 32'(n_flag - f0), 32'd1);
    chk("m43_dato", 32'(flag_dato), 32'h43);
    chk("m43_err", 32'(n_err - e0), 32'd0);

    // Make then break of the same key
    f0 = n_flag;
    send_frame(8'h5A);
    send_frame(8'hF0);
    send_frame(8'h5A);
    chk("brk_flags", 32'(n_flag - f0), 32'd1);
    chk("brk_fdato", 32'(flag_dato), 32'h5A);
    chk("brk_dato_held", 32'(Dato), 32'h5A);

    // Extended make and extended break
    f0 = n_flag;
    send_frame(8'hE0);
    send_frame(8'h75);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    chk("ext_flags", 32'(n_flag - f0), 32'd1);
    chk("ext_fdato", 32'(flag_dato), 32'h75);

    // Parity error, then recovery (also shows break_pend was cleared)
    f0 = n_flag; e0 = n_err;
    send_bits(8'h1C, 1'b1, 11);
    chk("par_err", 32'(n_err - e0), 32'd1);
    chk("par_noflag", 32'(n_flag - f0), 32'd0);
    chk("par_dato", 32'(Dato), 32'h75);
    send_frame(8'h34);
    chk("rec34_flags", 32'(n_flag - f0), 32'd1);
    chk("rec34_dato", 32'(Dato), 32'h34);

    // Watchdog: stall after five falling edges
    f0 = n_flag; e0 = n_err;
    send_bits(8'h55, 1'b0, 5);
    cyc(300);
    chk("wd_early", 32'(n_err - e0), 32'd0);
    cyc(400);
    chk("wd_fire", 32'(n_err - e0), 32'd1);
    chk("wd_noflag", 32'(n_flag - f0), 32'd0);
    send_frame(8'h33);
    chk("rec33_flags", 32'(n_flag - f0), 32'd1);
    chk("rec33_dato", 32'(Dato), 32'h33);

    // Reset mid-frame
    f0 = n_flag; e0 = n_err;
    send_bits(8'h66, 1'b0, 4);
    RESET = 1'b1;
    cyc(2);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_dato", 32'(Dato), 32'h00);
    chk("rst_flag", 32'(flag), 32'h0);
    cyc(TIMEOUT + 100);
    chk("rst_noerr", 32'(n_err - e0), 32'd0);
    chk("rst_noflag", 32'(n_flag - f0), 32'd0);

    // Short clock glitches with data low must not start a frame
    for (int g = 0; g < 3; g++) begin
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      cyc(3);
      ps2_clk  = 1'b1;
      cyc(30);
    end
    ps2_data = 1'b1;
    cyc(20);
    chk("glitch_noerr", 32'(n_err - e0), 32'd0);
    chk("glitch_noflag", 32'(n_flag - f0), 32'd0);
    send_frame(8'h29);
    chk("post_flags", 32'(n_flag - f0), 32'd1);
    chk("post_dato", 32'(Dato), 32'h29);
    chk("post_err", 32'(n_err - e0), 32'd0);

    // Typematic repeat gives one pulse per copy
    f0 = n_flag;
    send_frame(8'h1D);
    send_frame(8'h1D);
    chk("rep_flags", 32'(n_flag - f0), 32'd2);
    chk("rep_dato", 32'(Dato), 32'h1D);

    // Whole-run pulse properties
    chk("flag_err_overlap", 32'(n_both), 32'd0);
    chk("dato_settled", 32'(n_unstable), 32'd0);
    chk("flag_width", 32'(n_wide), 32'd0);
    chk("total_flags", 32'(n_flag), 32'd8);
    chk("total_errs", 32'(n_err), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
